// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: access-size encodings, FSM states and
// the byte-enable/write-data bundle produced by the alignment network.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_align_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for the MEM stage: byte enables and replicated
// store data going out, lane-selected and extended load data coming back.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output mem_align_t  align,
   output logic [31:0] load_data
);

   logic [7:0]  rd_byte [4];
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign rd_byte[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   assign lane_b = rd_byte[addr_lo];
   assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   // Size 2'b11 falls into the default arm and behaves as a word.
   always_comb begin
      align.be    = 4'b0000;
      align.wdata = 32'h0;
      load_data   = 32'h0;
      case (size)
         SZ_BYTE: begin
            align.be    = 4'b0001 << addr_lo;
            align.wdata = {4{store_data[7:0]}};
            load_data   = {{24{sgn & lane_b[7]}}, lane_b};
         end
         SZ_HALF: begin
            align.be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            align.wdata = {2{store_data[15:0]}};
            load_data   = {{16{sgn & lane_h[15]}}, lane_h};
         end
         default: begin
            align.be    = 4'b1111;
            align.wdata = store_data;
            load_data   = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: latches the EX result, runs loads/stores over a req/ack port
// and stalls upstream while waiting. Define MEM_MISALIGN_EXC_EN for misalign traps.
module mem_stage
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        regWr,
   input  logic [4:0]  regAddr,
   input  logic [31:0] aluResult,
   input  logic [31:0] storeData,
   input  logic        memRd,
   input  logic        memWr,
   input  logic [1:0]  memSize,
   input  logic        memSigned,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
`ifdef MEM_MISALIGN_EXC_EN
   output logic        excMisalign,
   output logic [31:0] excAddr,
`endif
   output logic        wbRegWr,
   output logic [4:0]  wbRegAddr,
   output logic [31:0] wbRegData
);

   logic        regwr_reg;
   logic [4:0]  regaddr_reg;
   logic [31:0] alu_reg;
   logic [31:0] sd_reg;
   logic        memrd_reg;
   logic        memwr_reg;
   logic [1:0]  size_reg;
   logic        signed_reg;

   mem_state_t  state_reg, state_next;
   mem_align_t  align;
   logic [31:0] load_data;
   logic        mem_op;
   logic        wb_block;

   // Input latch: a reset leaves an all-zero bubble; a stall freezes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         regwr_reg   <= 1'b0;
         regaddr_reg <= 5'd0;
         alu_reg     <= 32'h0;
         sd_reg      <= 32'h0;
         memrd_reg   <= 1'b0;
         memwr_reg   <= 1'b0;
         size_reg    <= SZ_BYTE;
         signed_reg  <= 1'b0;
      end else if (!stall) begin
         regwr_reg   <= regWr;
         regaddr_reg <= regAddr;
         alu_reg     <= aluResult;
         sd_reg      <= storeData;
         memrd_reg   <= memRd;
         memwr_reg   <= memWr;
         size_reg    <= memSize;
         signed_reg  <= memSigned;
      end
   end

`ifdef MEM_MISALIGN_EXC_EN
   logic misaligned;
   assign misaligned  = (size_reg == SZ_HALF) ? alu_reg[0] :
                        (size_reg[1]          ? (alu_reg[1:0] != 2'b00) : 1'b0);
   assign mem_op      = (memrd_reg | memwr_reg) & ~misaligned;
   assign excMisalign = (memrd_reg | memwr_reg) & misaligned;
   assign excAddr     = excMisalign ? alu_reg : 32'h0;
   assign wb_block    = excMisalign;
`else
   assign mem_op      = memrd_reg | memwr_reg;
   assign wb_block    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (mem_op && !dmem_ack) state_next = WAIT;
         WAIT:    if (dmem_ack)            state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The latch is frozen in WAIT, so the request fields stay stable for free.
   always_comb begin
      dmem_req = 1'b0;
      stall    = 1'b0;
      case (state_reg)
         IDLE: begin
            dmem_req = mem_op;
            stall    = mem_op & ~dmem_ack;
         end
         WAIT: begin
            dmem_req = 1'b1;
            stall    = ~dmem_ack;
         end
         default: ;
      endcase
   end

   mem_align u_align (
      .size       (size_reg),
      .sgn        (signed_reg),
      .addr_lo    (alu_reg[1:0]),
      .store_data (sd_reg),
      .rdata      (dmem_rdata),
      .align      (align),
      .load_data  (load_data)
   );

   assign dmem_we    = memwr_reg & mem_op;
   assign dmem_addr  = mem_op ? {alu_reg[31:2], 2'b00} : 32'h0;
   assign dmem_be    = mem_op ? align.be : 4'b0000;
   assign dmem_wdata = dmem_we ? align.wdata : 32'h0;

   assign wbRegWr    = regwr_reg & ~stall & ~wb_block;
   assign wbRegAddr  = regaddr_reg;
   assign wbRegData  = memrd_reg ? load_data : alu_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores with wait states,
// reset during WAIT, and (with MEM_MISALIGN_EXC_EN) the misalign trap.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        regWr;
   logic [4:0]  regAddr;
   logic [31:0] aluResult;
   logic [31:0] storeData;
   logic        memRd;
   logic        memWr;
   logic [1:0]  memSize;
   logic        memSigned;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        wbRegWr;
   logic [4:0]  wbRegAddr;
   logic [31:0] wbRegData;
`ifdef MEM_MISALIGN_EXC_EN
   logic        excMisalign;
   logic [31:0] excAddr;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .regWr      (regWr),
      .regAddr    (regAddr),
      .aluResult  (aluResult),
      .storeData  (storeData),
      .memRd      (memRd),
      .memWr      (memWr),
      .memSize    (memSize),
      .memSigned  (memSigned),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .stall      (stall),
`ifdef MEM_MISALIGN_EXC_EN
      .excMisalign(excMisalign),
      .excAddr    (excAddr),
`endif
      .wbRegWr    (wbRegWr),
      .wbRegAddr  (wbRegAddr),
      .wbRegData  (wbRegData)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Present one EX instruction (captured at the next rising edge).
   task automatic ex(input logic wr, input logic [4:0] ra, input logic [31:0] alu,
                     input logic [31:0] sd, input logic rd, input logic st,
                     input logic [1:0] sz, input logic sg);
      regWr = wr; regAddr = ra; aluResult = alu; storeData = sd;
      memRd = rd; memWr = st; memSize = sz; memSigned = sg;
   endtask

   task automatic bubble();
      ex(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   // Advance one cycle; new inputs go in 1 ns after the edge, checks 1 ns later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      ex(1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'b10, 1'b1);
      cyc(); cyc();
      #1;
      $display("txn reset");
      chk("rst_wbRegWr",   {31'h0, wbRegWr},  32'h0);
      chk("rst_wbRegAddr", {27'h0, wbRegAddr}, 32'h0);
      chk("rst_wbRegData", wbRegData,         32'h0);
      chk("rst_req",       {31'h0, dmem_req}, 32'h0);
      chk("rst_we",        {31'h0, dmem_we},  32'h0);
      chk("rst_addr",      dmem_addr,         32'h0);
      chk("rst_be",        {28'h0, dmem_be},  32'h0);
      chk("rst_wdata",     dmem_wdata,        32'h0);
      chk("rst_stall",     {31'h0, stall},    32'h0);
`ifdef MEM_MISALIGN_EXC_EN
      chk("rst_excMis",    {31'h0, excMisalign}, 32'h0);
      chk("rst_excAddr",   excAddr,           32'h0);
`endif

      // ALU op
      cyc(); rst = 1'b0;
      ex(1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
      cyc(); bubble(); #1;
      $display("txn alu r5=0x1234");
      chk("alu_wbRegWr",   {31'h0, wbRegWr},  32'h1);
      chk("alu_wbRegAddr", {27'h0, wbRegAddr}, 32'd5);
      chk("alu_wbRegData", wbRegData,         32'h0000_1234);
      chk("alu_req",       {31'h0, dmem_req}, 32'h0);

      // Signed byte load at 0x102, two wait cycles
      ex(1'b1, 5'd7, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
      cyc(); bubble(); dmem_rdata = 32'h80FF_0000; dmem_ack = 1'b0; #1;
      $display("txn lb 0x102 wait1");
      chk("lb_w1_stall",   {31'h0, stall},    32'h1);
      chk("lb_w1_wbRegWr", {31'h0, wbRegWr},  32'h0);
      chk("lb_w1_req",     {31'h0, dmem_req}, 32'h1);
      chk("lb_w1_addr",    dmem_addr,         32'h0000_0100);
      chk("lb_w1_be",      {28'h0, dmem_be},  32'h4);
      cyc(); #1;
      $display("txn lb 0x102 wait2");
      chk("lb_w2_stall",   {31'h0, stall},    32'h1);
      chk("lb_w2_wbRegWr", {31'h0, wbRegWr},  32'h0);
      chk("lb_w2_req",     {31'h0, dmem_req}, 32'h1);
      chk("lb_w2_addr",    dmem_addr,         32'h0000_0100);
      chk("lb_w2_be",      {28'h0, dmem_be},  32'h4);
      cyc(); dmem_ack = 1'b1; #1;
      $display("txn lb 0x102 ack");
      chk("lb_ack_stall",   {31'h0, stall},    32'h0);
      chk("lb_ack_wbRegWr", {31'h0, wbRegWr},  32'h1);
      chk("lb_ack_wbAddr",  {27'h0, wbRegAddr}, 32'd7);
      chk("lb_ack_wbData",  wbRegData,         32'hFFFF_FFFF);
      cyc(); dmem_ack = 1'b0; #1;
      $display("txn bubble after lb");
      chk("post_lb_req",     {31'h0, dmem_req}, 32'h0);
      chk("post_lb_wbRegWr", {31'h0, wbRegWr},  32'h0);

      // Halfword store at 0x22, zero wait, followed back-to-back by loads
      ex(1'b0, 5'd0, 32'h0000_0022, 32'hAABB_CCDD, 1'b0, 1'b1, 2'b01, 1'b0);
      cyc(); dmem_ack = 1'b1;
      ex(1'b1, 5'd9, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
      #1;
      $display("txn sh 0x22");
      chk("sh_we",      {31'h0, dmem_we},  32'h1);
      chk("sh_be",      {28'h0, dmem_be},  32'hC);
      chk("sh_wdata",   dmem_wdata,        32'hCCDD_CCDD);
      chk("sh_addr",    dmem_addr,         32'h0000_0020);
      chk("sh_stall",   {31'h0, stall},    32'h0);
      chk("sh_wbRegWr", {31'h0, wbRegWr},  32'h0);

      cyc(); dmem_rdata = 32'h1234_8001;
      ex(1'b1, 5'd10, 32'h0000_0002, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
      #1;
      $display("txn lhu 0x0");
      chk("lhu_data",  wbRegData,         32'h0000_8001);
      chk("lhu_wr",    {31'h0, wbRegWr},  32'h1);
      chk("lhu_be",    {28'h0, dmem_be},  32'h3);
      chk("lhu_stall", {31'h0, stall},    32'h0);

      cyc(); dmem_rdata = 32'h8001_1234;
      ex(1'b1, 5'd11, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
      #1;
      $display("txn lh 0x2");
      chk("lh_data", wbRegData, 32'hFFFF_8001);
      chk("lh_be",   {28'h0, dmem_be}, 32'hC);

      cyc(); dmem_rdata = 32'hFFFF_FF7F;
      ex(1'b0, 5'd0, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0);
      #1;
      $display("txn lb 0x40 positive");
      chk("lb_pos_data", wbRegData, 32'h0000_007F);
      chk("lb_pos_be",   {28'h0, dmem_be}, 32'h1);

      cyc();
      ex(1'b0, 5'd0, 32'h0000_0003, 32'h1234_56EF, 1'b0, 1'b1, 2'b00, 1'b0);
      #1;
      $display("txn sw 0x44");
      chk("sw_be",    {28'h0, dmem_be}, 32'hF);
      chk("sw_wdata", dmem_wdata,       32'hDEAD_BEEF);
      chk("sw_addr",  dmem_addr,        32'h0000_0044);

      cyc();
`ifdef MEM_MISALIGN_EXC_EN
      bubble();
`else
      ex(1'b1, 5'd12, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
`endif
      #1;
      $display("txn sb 0x3");
      chk("sb_be",    {28'h0, dmem_be}, 32'h8);
      chk("sb_wdata", dmem_wdata,       32'hEFEF_EFEF);

`ifndef MEM_MISALIGN_EXC_EN
      cyc(); dmem_rdata = 32'hCAFE_F00D; bubble(); #1;
      $display("txn lw 0x103 unchecked-align");
      chk("lw_mis_addr", dmem_addr, 32'h0000_0100);
      chk("lw_mis_be",   {28'h0, dmem_be}, 32'hF);
      chk("lw_mis_data", wbRegData, 32'hCAFE_F00D);
`endif

      // Unsolicited ack with no pending op
      cyc(); dmem_ack = 1'b1; #1;
      $display("txn unsolicited ack");
      chk("unsol_req",   {31'h0, dmem_req}, 32'h0);
      chk("unsol_stall", {31'h0, stall},    32'h0);

      // Reset while in WAIT
      cyc(); dmem_ack = 1'b0;
      ex(1'b1, 5'd13, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      cyc(); bubble(); #1;
      chk("rw_req_idle", {31'h0, dmem_req}, 32'h1);
      cyc(); rst = 1'b1; #1;
      $display("txn reset during wait");
      chk("rw_req_wait",   {31'h0, dmem_req}, 32'h1);
      chk("rw_stall_wait", {31'h0, stall},    32'h1);
      cyc(); rst = 1'b0; #1;
      chk("rw_req_after",   {31'h0, dmem_req}, 32'h0);
      chk("rw_stall_after", {31'h0, stall},    32'h0);
      cyc(); dmem_ack = 1'b1; #1;
      $display("txn late ack after reset");
      chk("rw_late_wbRegWr", {31'h0, wbRegWr},  32'h0);
      chk("rw_late_req",     {31'h0, dmem_req}, 32'h0);
      cyc(); dmem_ack = 1'b0;

`ifdef MEM_MISALIGN_EXC_EN
      // Misaligned word load traps instead of accessing memory
      ex(1'b1, 5'd14, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      cyc(); bubble(); #1;
      $display("txn lw 0x101 misaligned");
      chk("mis_req",     {31'h0, dmem_req},    32'h0);
      chk("mis_exc",     {31'h0, excMisalign}, 32'h1);
      chk("mis_excAddr", excAddr,              32'h0000_0101);
      chk("mis_wbRegWr", {31'h0, wbRegWr},     32'h0);
      chk("mis_stall",   {31'h0, stall},       32'h0);
      cyc(); #1;
      chk("mis_exc_end", {31'h0, excMisalign}, 32'h0);
`endif

      cyc();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
